// File: rtl/popcnt_sched.sv
// ---------------------------------------------------------------------------
// PopcntSched -- round-robin word scheduler with a bit-serial population count
//
// Several requesters offer data words. While idle, the block grants one of
// them round-robin, captures its word and then counts the 1 bits one bit per
// clock (W cycles). The result is held until the consumer accepts it.
//
// Ports
//   clk_i        single clock, all state changes on the rising edge
//   reset_i      synchronous active-high reset
//   req_valid_i  per-requester word-available flags            [N_REQ]
//   req_data_i   packed words, requester i at [i*W +: W]        [N_REQ*W]
//   req_ready_o  one-hot grant, only ever high while idle       [N_REQ]
//   rsp_valid_o  result available (DONE state)
//   rsp_ready_i  consumer accepts the result
//   rsp_count_o  number of 1 bits in the granted word         [clog2(W+1)]
//   rsp_id_o     index of the requester owning rsp_count_o    [clog2(N_REQ)]
//   busy_o       high while a word is being counted or held
// ---------------------------------------------------------------------------
module popcnt_sched #(
  parameter int N_REQ = 4,
  parameter int W     = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [N_REQ-1:0]           req_valid_i,
  input  logic [N_REQ*W-1:0]         req_data_i,
  output logic [N_REQ-1:0]           req_ready_o,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [$clog2(W+1)-1:0]     rsp_count_o,
  output logic [$clog2(N_REQ)-1:0]   rsp_id_o,
  output logic                       busy_o
);

  localparam int CW  = $clog2(W+1);
  localparam int IDW = $clog2(N_REQ);
  localparam int BW  = $clog2(W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } stateT;

  stateT            state_q, state_d;
  logic [W-1:0]     shift_q, shift_d;
  logic [CW-1:0]    count_q, count_d;
  logic [BW-1:0]    bitIdx_q, bitIdx_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   lastGrant_q, lastGrant_d;
  logic [CW-1:0]    rspCount_q, rspCount_d;
  logic [IDW-1:0]   rspId_q, rspId_d;

  logic             found;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   cand;
  logic [N_REQ-1:0] grant;
  logic [W-1:0]     winnerWord;

  // Round-robin search: walk the requesters starting just after the last
  // accepted one and wrapping, and take the first valid one.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDW'((int'(lastGrant_q) + k) % N_REQ);
      if (!found && req_valid_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Turn the winner index into a one-hot grant and pick its word; only the
  // winner's lane is ever routed into the shift register.
  always_comb begin
    grant      = '0;
    winnerWord = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (found && (winner == IDW'(i))) begin
        grant[i]   = 1'b1;
        winnerWord = req_data_i[i*W +: W];
      end
    end
  end

  // Next-state logic. The count adds one bit per COUNT cycle; the edge that
  // consumes the last bit also publishes the result registers, so the
  // visible count/id only change when a new result becomes valid.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    count_d     = count_q;
    bitIdx_d    = bitIdx_q;
    id_d        = id_q;
    lastGrant_d = lastGrant_q;
    rspCount_d  = rspCount_q;
    rspId_d     = rspId_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          shift_d     = winnerWord;
          id_d        = winner;
          count_d     = '0;
          bitIdx_d    = '0;
          lastGrant_d = winner;
          state_d     = COUNT;
        end
      end
      COUNT: begin
        count_d  = count_q + CW'(shift_q[0]);
        shift_d  = shift_q >> 1;
        bitIdx_d = bitIdx_q + 1'b1;
        if (bitIdx_q == BW'(W-1)) begin
          rspCount_d = count_q + CW'(shift_q[0]);
          rspId_d    = id_q;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset wins over any handshake in the same cycle and
  // throws away a word that is still in flight.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      count_q     <= '0;
      bitIdx_q    <= '0;
      id_q        <= '0;
      lastGrant_q <= IDW'(N_REQ-1);
      rspCount_q  <= '0;
      rspId_q     <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      count_q     <= count_d;
      bitIdx_q    <= bitIdx_d;
      id_q        <= id_d;
      lastGrant_q <= lastGrant_d;
      rspCount_q  <= rspCount_d;
      rspId_q     <= rspId_d;
    end
  end

  // The grant is combinational from the current requests, but is masked
  // outside IDLE and while reset is asserted.
  assign req_ready_o = ((state_q == IDLE) && !reset_i) ? grant : '0;
  assign rsp_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign rsp_count_o = rspCount_q;
  assign rsp_id_o    = rspId_q;

endmodule

// File: tb/tb_popcnt_sched.sv
// ---------------------------------------------------------------------------
// Directed testbench for popcnt_sched (N_REQ=4, W=16).
// Inputs are driven on the falling edge and outputs are sampled on the
// falling edge, away from the rising edge where the design updates.
// ---------------------------------------------------------------------------
module tb_popcnt_sched;

  logic        clk;
  logic        reset;
  logic [3:0]  reqValid;
  logic [63:0] reqData;
  logic [3:0]  reqReady;
  logic        rspValid;
  logic        rspReady;
  logic [4:0]  rspCount;
  logic [1:0]  rspId;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  popcnt_sched #(.N_REQ(4), .W(16)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_valid_i (reqValid),
    .req_data_i  (reqData),
    .req_ready_o (reqReady),
    .rsp_valid_o (rspValid),
    .rsp_ready_i (rspReady),
    .rsp_count_o (rspCount),
    .rsp_id_o    (rspId),
    .busy_o      (busy)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present a request pattern and its packed data words.
  task automatic applyStimulus(input logic [3:0] valid, input logic [63:0] data);
    reqValid = valid;
    reqData  = data;
  endtask

  // Reset for two cycles with all requests raised; the grant must stay low
  // and every output must read its reset value.
  task automatic doReset();
    reset    = 1'b1;
    rspReady = 1'b0;
    applyStimulus(4'b1111, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset.reqReady", {28'd0, reqReady}, 32'd0);
    checkOutput("reset.rspValid", {31'd0, rspValid}, 32'd0);
    checkOutput("reset.busy",     {31'd0, busy},     32'd0);
    checkOutput("reset.rspCount", {27'd0, rspCount}, 32'd0);
    checkOutput("reset.rspId",    {30'd0, rspId},    32'd0);
    reset = 1'b0;
    applyStimulus(4'b0000, 64'd0);
  endtask

  // One full transaction, starting and ending at a falling edge in IDLE.
  // holdCycles > 0 keeps rsp_ready low that many cycles in DONE;
  // readyHeld keeps rsp_ready high the whole time (ignored outside DONE).
  task automatic runTxn(input string tag, input logic [3:0] valid,
                        input logic [63:0] data, input int expId,
                        input int expCount, input int holdCycles,
                        input bit readyHeld);
    logic [3:0] expGrant;
    int lat;
    expGrant = 4'b0001 << expId;
    applyStimulus(valid, data);
    rspReady = readyHeld;
    #1;
    checkOutput({tag, ".grant"}, {28'd0, reqReady}, {28'd0, expGrant});
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    checkOutput({tag, ".readyLowInCount"}, {28'd0, reqReady}, 32'd0);
    checkOutput({tag, ".busyInCount"},     {31'd0, busy},     32'd1);
    while (!rspValid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, ".latency"},  lat, 32'd17);
    checkOutput({tag, ".rspCount"}, {27'd0, rspCount}, expCount);
    checkOutput({tag, ".rspId"},    {30'd0, rspId},    expId);
    for (int h = 0; h < holdCycles; h++) begin
      @(negedge clk);
      checkOutput({tag, ".holdValid"}, {31'd0, rspValid}, 32'd1);
      checkOutput({tag, ".holdCount"}, {27'd0, rspCount}, expCount);
      checkOutput({tag, ".holdId"},    {30'd0, rspId},    expId);
      checkOutput({tag, ".holdReady"}, {28'd0, reqReady}, 32'd0);
      checkOutput({tag, ".holdBusy"},  {31'd0, busy},     32'd1);
    end
    rspReady = 1'b1;
    @(negedge clk);
    checkOutput({tag, ".released"}, {31'd0, rspValid}, 32'd0);
    rspReady = 1'b0;
  endtask

  initial begin
    bit seenRsp;
    reset    = 1'b1;
    rspReady = 1'b0;
    applyStimulus(4'b0000, 64'd0);
    @(negedge clk);
    doReset();

    // Single request; other lanes carry all-ones so a wrong lane shows up.
    runTxn("single", 4'b0001, 64'hFFFF_FFFF_FFFF_A5A5, 0, 8, 0, 1'b0);
    applyStimulus(4'b0000, 64'd0);

    // Boundary words on requester 0 (last grant 0, only 0 valid -> 0 again).
    runTxn("allOnes",  4'b0001, 64'h0F0F_3333_7777_FFFF, 0, 16, 0, 1'b0);
    runTxn("allZeros", 4'b0001, 64'h0F0F_3333_7777_0000, 0, 0,  0, 1'b0);
    runTxn("endBits",  4'b0001, 64'h0F0F_3333_7777_8001, 0, 2,  0, 1'b0);
    applyStimulus(4'b0000, 64'd0);

    // Round-robin with all requesters held; the last one also backpressures.
    doReset();
    runTxn("rr0", 4'b1111, 64'h000F_0007_0003_0001, 0, 1, 0, 1'b1);
    runTxn("rr1", 4'b1111, 64'h000F_0007_0003_0001, 1, 2, 0, 1'b1);
    runTxn("rr2", 4'b1111, 64'h000F_0007_0003_0001, 2, 3, 0, 1'b1);
    runTxn("rr3", 4'b1111, 64'h000F_0007_0003_0001, 3, 4, 0, 1'b1);
    runTxn("rrBp", 4'b1111, 64'h000F_0007_0003_0001, 0, 1, 10, 1'b0);
    applyStimulus(4'b0000, 64'd0);

    // Reset on the 8th COUNT cycle abandons the word for requester 2.
    doReset();
    applyStimulus(4'b0100, 64'h0000_1234_0000_0000);
    #1;
    checkOutput("abort.grant", {28'd0, reqReady}, 32'h4);
    @(posedge clk);
    @(negedge clk);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    applyStimulus(4'b0000, 64'd0);
    @(negedge clk);
    checkOutput("abort.busy",     {31'd0, busy},     32'd0);
    checkOutput("abort.rspValid", {31'd0, rspValid}, 32'd0);
    checkOutput("abort.reqReady", {28'd0, reqReady}, 32'd0);
    reset = 1'b0;
    seenRsp = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (rspValid) seenRsp = 1'b1;
    end
    checkOutput("abort.noResponse", {31'd0, seenRsp}, 32'd0);
    runTxn("afterAbort", 4'b1111, 64'h0000_0000_0000_00FF, 0, 8, 0, 1'b0);
    applyStimulus(4'b0000, 64'd0);

    // Sparse wrap: make last grant 2, flash an unanswered grant to 0, then
    // 0011 must still go to 0 and 0010 to 1.
    doReset();
    runTxn("setLast2", 4'b0100, 64'h0000_0003_0000_0000, 2, 2, 0, 1'b0);
    applyStimulus(4'b0001, 64'd0);
    #1;
    checkOutput("flash.grant", {28'd0, reqReady}, 32'h1);
    #2;
    applyStimulus(4'b0000, 64'd0);
    @(negedge clk);
    checkOutput("flash.notAccepted", {31'd0, busy}, 32'd0);
    runTxn("wrap0", 4'b0011, 64'h0000_0000_00F0_0101, 0, 2, 0, 1'b0);
    runTxn("wrap1", 4'b0010, 64'h0000_0000_00F0_0101, 1, 4, 0, 1'b0);
    applyStimulus(4'b0000, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/popcnt_sched.md
POPCNT_SCHED -- requirements
Module: popcnt_sched

Interface
REQ-001 Parameter N_REQ, default 4, meaning number of requesters (2..8).
REQ-002 Parameter W, default 16, meaning data word width in bits.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 req_valid  input  N_REQ  per-requester word-available flag.
REQ-006 req_data  input  N_REQ*W  packed words; requester i occupies bits [i*W +: W].
REQ-007 req_ready  output  N_REQ  one-hot grant; a word transfers when req_valid[i] and req_ready[i] are both high.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer accepts result.
REQ-010 rsp_count  output  clog2(W+1)  number of 1s in the granted word (5 bits at W=16).
REQ-011 rsp_id  output  clog2(N_REQ)  index of the requester that owns rsp_count.
REQ-012 busy  output  1  high in COUNT or DONE.

Function
REQ-013 The FSM shall have three states: IDLE, COUNT, DONE.
REQ-014 IDLE: if no req_valid bit is set, remain in IDLE and drive req_ready all-zero.
REQ-015 IDLE: if any req_valid bit is set, assert req_ready combinationally to exactly one winner, chosen round-robin: first set bit at or after index (last_grant+1) mod N_REQ, wrapping.
REQ-016 req_ready shall be all-zero in COUNT and DONE; no second word is accepted while one is in flight.
REQ-017 On the acceptance edge: latch the winner's word into a shift register, latch rsp_id = winner, clear the count to 0, clear the bit index to 0, update last_grant = winner, move to COUNT.
REQ-018 COUNT: each cycle add exactly one bit (LSB of shift register) to the count, shift right by one, increment the bit index.
REQ-019 COUNT shall last exactly W cycles; the edge that processes bit W-1 shall move to DONE.
REQ-020 Latency: rsp_valid rises exactly W+1 cycles after the acceptance edge (17 at W=16), independent of data.
REQ-021 Count arithmetic shall not wrap: all-ones word yields W (16 = 5'b10000); all-zeros yields 0.
REQ-022 DONE: hold rsp_valid=1 with rsp_count and rsp_id stable until rsp_ready=1.
REQ-023 On an edge with rsp_valid=1 and rsp_ready=1: drop rsp_valid and return to IDLE; a new grant is possible the following cycle.
REQ-024 rsp_ready while not in DONE shall be ignored.
REQ-025 Requests deasserted before grant shall be dropped without side effects; req_data of non-granted requesters is never sampled.
REQ-026 last_grant shall update only on an accepted transfer, never on an unanswered grant.
REQ-027 rsp_count and rsp_id outside DONE shall hold their last values (undefined to the consumer).

Reset
REQ-028 Reset shall force IDLE, rsp_valid=0, busy=0, rsp_count=0, rsp_id=0, bit index 0, and last_grant=N_REQ-1, so requester 0 has first priority.
REQ-029 Reset in COUNT or DONE shall abandon the in-flight word; no response is ever emitted for it.
REQ-030 Reset takes priority over every other event in the same cycle, including simultaneous handshakes.
REQ-031 req_ready shall be all-zero while reset is high.

Verification
REQ-032 Single request: after reset, req_valid=4'b0001 with data 16'hA5A5 -> req_ready=4'b0001 for one cycle; rsp_valid 17 cycles later with rsp_count=8, rsp_id=0.
REQ-033 Boundary data: 16'hFFFF -> rsp_count=16; 16'h0000 -> rsp_count=0; 16'h8001 -> rsp_count=2.
REQ-034 Round-robin: req_valid=4'b1111 held, rsp_ready=1 -> grant order 0,1,2,3,0; each rsp_id matches.
REQ-035 Backpressure: rsp_ready=0 for 10 cycles in DONE -> rsp_valid, rsp_count and rsp_id stable, req_ready=0, busy=1; releases one cycle after rsp_ready=1.
REQ-036 Reset mid-COUNT: reset on the 8th COUNT cycle -> next cycle IDLE, rsp_valid=0, no response for the aborted word; the next grant goes to requester 0.
REQ-037 Sparse wrap: last_grant=2, req_valid=4'b0011 -> grant requester 0; then req_valid=4'b0010 -> grant requester 1.
